// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and owner tag shared by the core, the decoder and the data memory arbiter
package cpu_pkg;
  localparam int MEM_AW = 10;
  localparam int DW = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;
endpackage

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between CPU and loader; DATA_MEM_ARB_ROUND_ROBIN_EN enables round-robin on contention
module data_mem_arbiter #(
  parameter int MEM_AW = cpu_pkg::MEM_AW,
  parameter int DW = cpu_pkg::DW,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [MEM_AW-1:0] cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [MEM_AW-1:0] ldr_addr,
  input  logic [DW-1:0]     ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);
  import cpu_pkg::*;
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic              locked_q, locked_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              at_max, pick_ldr, gnt_any, sel_we;
  logic [MEM_AW-1:0] sel_addr;
  logic [DW-1:0]     sel_wdata;
  owner_t            own_q1, own_q2;
  logic              we2_q;
  logic              mem_en_q, mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [DW-1:0]     mem_wdata_q, rdata_q;
  logic              cpu_rvalid_q, ldr_rvalid_q;

  assign at_max = cnt_q == CW'(LOCK_MAX);

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;
  assign pick_ldr = rr_q & ldr_req;
  assign rr_d = (cpu_req & ldr_req & ~locked_q) ? cpu_gnt : rr_q;
  // Pointer favours whoever lost the last contended unlocked grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else rr_q <= rr_d;
  end
`else
  assign pick_ldr = 1'b0;
`endif

  // Grant: a lock gives the loader the bus until its burst budget is spent
  always_comb begin
    cpu_gnt = cpu_req & ~(locked_q ? (ldr_req & ~at_max) : pick_ldr);
    ldr_gnt = ldr_req & ~cpu_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
    gnt_any = cpu_gnt | ldr_gnt;
    sel_we = cpu_gnt ? cpu_we : ldr_we;
    sel_addr = cpu_gnt ? cpu_addr : ldr_addr;
    sel_wdata = cpu_gnt ? cpu_wdata : ldr_wdata;
  end

  // Lock state: dropping ldr_lock wins over a simultaneous budget expiry
  always_comb begin
    locked_d = locked_q;
    cnt_d = cnt_q;
    if (!ldr_lock) begin
      locked_d = 1'b0;
      cnt_d = '0;
    end else if (cpu_gnt && locked_q && at_max) begin
      cnt_d = '0;
    end else if (ldr_gnt) begin
      locked_d = 1'b1;
      cnt_d = !locked_q ? CW'(1) : at_max ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Registered RAM command, owner pipeline and read return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q <= 1'b0;
      cnt_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      own_q1 <= OWN_NONE;
      own_q2 <= OWN_NONE;
      we2_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      locked_q <= locked_d;
      cnt_q <= cnt_d;
      mem_en_q <= gnt_any;
      mem_we_q <= gnt_any & sel_we;
      if (gnt_any) begin
        mem_addr_q <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      own_q1 <= cpu_gnt ? OWN_CPU : ldr_gnt ? OWN_LDR : OWN_NONE;
      own_q2 <= own_q1;
      we2_q <= mem_we_q;
      cpu_rvalid_q <= own_q2 == OWN_CPU && !we2_q;
      ldr_rvalid_q <= own_q2 == OWN_LDR && !we2_q;
      if (own_q2 != OWN_NONE && !we2_q) rdata_q <= mem_rdata;
    end
  end

  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata = rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
endmodule
